vga_text_console: RTL and testbench
===================================

Name: vga_text_console

Overview:
Parametrised VGA text console peripheral for the TinyQV peripheral bus. It holds a COLS x ROWS character buffer with a per-cell foreground colour. It renders 5x7 glyphs on a 6x8 cell grid, scaled by 2^SCALE_LOG2, through a 1-cycle registered pixel pipeline. Added features: auto-incrementing write pointer, a blinking inverse cursor, programmable colours, and a hardware clear engine. It sits beside the existing sync generator and glyph ROM; RGB goes to the TinyVGA PMOD mapping.

Parameters:
COLS, 12, characters per row (1..32)
ROWS, 3, character rows (1..8); N = COLS*ROWS cells, IW = clog2(N)
SCALE_LOG2, 3, screen pixels per glyph pixel = 2^SCALE_LOG2
ORIGIN_X, 48, left edge of text area in pixels
ORIGIN_Y, 64, top edge of text area in pixels
BLINK_FRAMES, 32, frames per cursor blink half-period

Ports:
clk  in  1  peripheral clock
reset  in  1  synchronous, active-high reset
address  in  6  register address
data_in  in  32  write data (bits [7:0] used)
data_write_n  in  2  11 none, 00 byte write (others treated as none)
data_read_n  in  2  11 none, else read
data_out  out  32  read data, zero-extended
data_ready  out  1  constant 1
pix_x  in  10  current pixel column from sync generator
pix_y  in  10  current pixel row
video_active  in  1  visible-region flag
frame_start  in  1  one-cycle pulse per frame
glyph_code  out  7  character code to glyph ROM (combinational)
glyph_bits  in  35  glyph row-major 5x7 bitmap; bit 34 = top-left
rgb  out  6  {R[1:0],G[1:0],B[1:0]}, registered

Behaviour:
- Interface decision: one clock `clk`; reset is synchronous and active-high on `reset`.
- Registers (byte writes):
  - 0x00 CURSOR: write sets ptr = data_in[IW-1:0] if < N, else the write is ignored; read returns ptr.
  - 0x01 DATA: write stores {fg, data_in[6:0]} at cell ptr, then ptr <= (ptr==N-1) ? 0 : ptr+1. Read returns {fg_cell[5:0], code[6:0]} of cell ptr in bits [12:0].
  - 0x02 FG: 6-bit foreground used for later DATA writes and clears; reset 6'b001100.
  - 0x03 CTRL: bit0 cursor_en (reset 1), bit1 blink_en (reset 1). Writing bit7=1 starts a clear. Read returns {busy, 5'b0, blink_en, cursor_en}.
  - 0x04 BG: 6-bit background; reset 0.
  - Other addresses read as 0; writes to them are ignored.
- Clear FSM:
  - IDLE --(CTRL bit7 write, or reset)--> CLEAR.
  - CLEAR writes code 0x20 with current FG to cell k at k = 0..N-1, one cell per cycle.
  - After cell N-1: ptr <= 0, go to IDLE.
  - busy = (state==CLEAR); it is high for exactly N cycles, including the N cycles after reset deasserts.
  - While busy: DATA and CURSOR writes are ignored and a further clear request is ignored. FG/BG/CTRL bits 0-1 writes take effect immediately.
  - Reset mid-clear restarts the clear from cell 0.
- Pixel pipeline:
  - rx = pix_x-ORIGIN_X, ry = pix_y-ORIGIN_Y.
  - In text area iff 0 <= rx < COLS*6*2^S and 0 <= ry < ROWS*8*2^S.
  - gx = rx>>S, gy = ry>>S; col = gx/6, row = gy/8, cx = gx%6, cy = gy%8; cell = row*COLS+col.
  - glyph_code = code[cell].
  - on = (cx<5) && (cy<7) && glyph_bits[34-(cy*5+cx)].
  - inv = cursor_en && cell==ptr && (!blink_en || blink_phase) && !busy.
  - colour = (on ^ inv) ? fg_cell : BG.
  - rgb at cycle t+1 = colour computed from inputs at cycle t when video_active && in text area; otherwise 0.
  - rgb resets to 0.
- Blink:
  - Counter increments on frame_start.
  - At count BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - Reset: counter 0, blink_phase 1.
- A read has no side effects; a DATA write and a pixel fetch in the same cycle are both honoured, and the pixel fetch sees the old cell value.

Test Plan:
- Reset, hold 1 cycle, release -> CTRL reads 0x83 for N=36 cycles, then 0x03. Every cell reads 0x0C20 via CURSOR/DATA reads; ptr=0.
- CURSOR=35, DATA write 'A' (0x41), DATA write 'B' -> cell 35=0x0C41, cell 0=0x0C42, ptr=1; CURSOR write 36 -> ignored, ptr stays 1.
- FG=0x30, cell 0='A'; pixel of glyph 'A' bit set at (ORIGIN_X, ORIGIN_Y+8) with video_active -> rgb=0x30 one cycle later. Gap column cx=5 -> rgb=BG. Same pixel with video_active=0 -> rgb=0.
- cursor_en=1, blink_en=0, ptr=0 -> cell 0 lit pixels output BG and background pixels output fg. Set blink_en=1 and pulse frame_start 32 times -> the inversion disappears; 32 more pulses -> the inversion returns.
- Start a clear, then DATA write at cycle 5 and another CTRL bit7 write -> both ignored; clear completes at cycle 36 and all cells = {FG,0x20}.
- Assert reset at cycle 10 of a clear -> clear restarts and busy stays high for 36 cycles after reset deasserts.

Source files
------------

// File: rtl/vga_text_console_if.sv
// TinyQV peripheral bus bundle for the text console.
// Handshake: data_ready is always 1. A byte write lands on the rising clk edge
// while data_write_n==2'b00. data_out is combinational and valid whenever
// data_read_n!=2'b11; it is 0 otherwise.
interface vga_text_console_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (output address, data_in, data_write_n, data_read_n,
                  input  data_out, data_ready);
  modport slave  (input  address, data_in, data_write_n, data_read_n,
                  output data_out, data_ready);
endinterface

// File: rtl/vga_text_console.sv
// VGA text console: character buffer with per-cell colour, clear engine, blinking
// inverse cursor and a one-cycle registered pixel path into the TinyVGA RGB mapping.
module vga_text_console #(
  parameter int COLS         = 12,
  parameter int ROWS         = 3,
  parameter int SCALE_LOG2   = 3,
  parameter int ORIGIN_X     = 48,
  parameter int ORIGIN_Y     = 64,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                clk,
  input  logic                reset,
  vga_text_console_if.slave   bus,
  input  logic [9:0]          pix_x,
  input  logic [9:0]          pix_y,
  input  logic                video_active,
  input  logic                frame_start,
  output logic [6:0]          glyph_code,
  input  logic [34:0]         glyph_bits,
  output logic [5:0]          rgb,
  output logic                dbg_state
);
  localparam int N  = COLS * ROWS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = COLS * 6 * (1 << SCALE_LOG2);
  localparam int TH = ROWS * 8 * (1 << SCALE_LOG2);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d, clr_q, clr_d;
  logic [6:0]      code_q [N];
  logic [6:0]      code_d [N];
  logic [5:0]      cfg_q [N];
  logic [5:0]      cfg_d [N];
  logic [5:0]      fg_q, fg_d, bg_q, bg_d, rgb_q, rgb_d;
  logic            cursor_en_q, cursor_en_d, blink_en_q, blink_en_d;
  logic            phase_q, phase_d;
  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;

  logic            busy, wr_en, rd_en;
  logic [10:0]     rx, ry, gx, gy, col, row, cell_full;
  logic [2:0]      cx, cy;
  logic            in_area, glyph_ok, on, inv;
  logic [5:0]      bit_idx, colour;
  logic [IW-1:0]   cell_idx;
  logic [31:0]     rdata;
  logic            unused_bits;

  assign busy      = (state_q == S_CLEAR);
  assign wr_en     = (bus.data_write_n == 2'b00);
  assign rd_en     = (bus.data_read_n != 2'b11);
  assign dbg_state = busy;

  // Pixel address decode: screen position -> cell and glyph-pixel coordinates.
  always_comb begin
    rx        = {1'b0, pix_x} - 11'(ORIGIN_X);
    ry        = {1'b0, pix_y} - 11'(ORIGIN_Y);
    in_area   = ({1'b0, pix_x} >= 11'(ORIGIN_X)) && (rx < 11'(TW)) &&
                ({1'b0, pix_y} >= 11'(ORIGIN_Y)) && (ry < 11'(TH));
    gx        = rx >> SCALE_LOG2;
    gy        = ry >> SCALE_LOG2;
    col       = gx / 11'd6;
    cx        = 3'(gx % 11'd6);
    row       = gy >> 3;
    cy        = gy[2:0];
    cell_full = row * 11'(COLS) + col;
    cell_idx  = in_area ? cell_full[IW-1:0] : '0;
    glyph_ok  = (cx < 3'd5) && (cy < 3'd7);
    bit_idx   = glyph_ok ? (6'd34 - (6'(cy) * 6'd5 + 6'(cx))) : 6'd0;
    on        = glyph_ok && glyph_bits[bit_idx];
    inv       = cursor_en_q && (cell_idx == ptr_q) && (!blink_en_q || phase_q) && !busy;
    colour    = (on ^ inv) ? cfg_q[cell_idx] : bg_q;
  end

  assign glyph_code  = code_q[cell_idx];
  assign rgb         = rgb_q;
  assign unused_bits = ^{bus.data_in[31:8], cell_full[10:IW]};

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    clr_d       = clr_q;
    code_d      = code_q;
    cfg_d       = cfg_q;
    fg_d        = fg_q;
    bg_d        = bg_q;
    cursor_en_d = cursor_en_q;
    blink_en_d  = blink_en_q;
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    rgb_d       = (video_active && in_area) ? colour : 6'd0;

    if (frame_start) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        phase_d     = !phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    if (busy) begin
      code_d[clr_q] = 7'h20;
      cfg_d[clr_q]  = fg_q;
      if (clr_q == IW'(N - 1)) begin
        state_d = S_IDLE;
        ptr_d   = '0;
        clr_d   = '0;
      end else begin
        clr_d = clr_q + 1'b1;
      end
    end

    // Buffer and pointer writes are locked out while the clear engine owns the buffer.
    if (wr_en) begin
      case (bus.address)
        6'h00: if (!busy && (32'(bus.data_in[IW-1:0]) < N)) ptr_d = bus.data_in[IW-1:0];
        6'h01: if (!busy) begin
          code_d[ptr_q] = bus.data_in[6:0];
          cfg_d[ptr_q]  = fg_q;
          ptr_d         = (ptr_q == IW'(N - 1)) ? '0 : ptr_q + 1'b1;
        end
        6'h02: fg_d = bus.data_in[5:0];
        6'h03: begin
          cursor_en_d = bus.data_in[0];
          blink_en_d  = bus.data_in[1];
          if (bus.data_in[7] && !busy) begin
            state_d = S_CLEAR;
            clr_d   = '0;
          end
        end
        6'h04: bg_d = bus.data_in[5:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (bus.address)
      6'h00: rdata[IW-1:0] = ptr_q;
      6'h01: rdata[12:0]   = {cfg_q[ptr_q], code_q[ptr_q]};
      6'h02: rdata[5:0]    = fg_q;
      6'h03: rdata[7:0]    = {busy, 5'b0, blink_en_q, cursor_en_q};
      6'h04: rdata[5:0]    = bg_q;
      default: ;
    endcase
    bus.data_out   = rd_en ? rdata : 32'd0;
    bus.data_ready = 1'b1;
  end

  // Reset lands in CLEAR so the buffer is wiped right after reset deasserts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_CLEAR;
      ptr_q       <= '0;
      clr_q       <= '0;
      fg_q        <= 6'b001100;
      bg_q        <= 6'd0;
      cursor_en_q <= 1'b1;
      blink_en_q  <= 1'b1;
      phase_q     <= 1'b1;
      blink_cnt_q <= '0;
      rgb_q       <= 6'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      clr_q       <= clr_d;
      fg_q        <= fg_d;
      bg_q        <= bg_d;
      cursor_en_q <= cursor_en_d;
      blink_en_q  <= blink_en_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
      rgb_q       <= rgb_d;
    end
  end

  always_ff @(posedge clk) begin
    code_q <= code_d;
    cfg_q  <= cfg_d;
  end
endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: register/bus sequences, a pixel vector table and
// multi-cycle clear/blink/reset corner cases, checked through an expected queue.
module tb_vga_text_console;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pix_x, pix_y;
  logic        video_active, frame_start;
  logic [6:0]  glyph_code;
  logic [34:0] glyph_bits;
  logic [5:0]  rgb;
  logic        dbg_state;

  vga_text_console_if bus();

  vga_text_console dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .video_active (video_active),
    .frame_start  (frame_start),
    .glyph_code   (glyph_code),
    .glyph_bits   (glyph_bits),
    .rgb          (rgb),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  localparam logic [34:0] GLYPH_A = 35'b01110_10001_10001_11111_10001_10001_10001;
  localparam logic [34:0] GLYPH_B = 35'b11110_10001_10001_11110_10001_10001_11110;

  // Minimal glyph ROM: only 'A' and 'B' have pixels.
  always_comb begin
    case (glyph_code)
      7'h41:   glyph_bits = GLYPH_A;
      7'h42:   glyph_bits = GLYPH_B;
      default: glyph_bits = 35'd0;
    endcase
  end

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    int         x;
    int         y;
    logic       va;
    logic [5:0] exp;
  } pix_vec_t;
  pix_vec_t tab[14];

  function automatic logic [31:0] cell_val(input logic [5:0] fg, input logic [6:0] code);
    return {19'd0, fg, code};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got 0x%0h with no expected entry", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address      = a;
    bus.data_in      = {24'd0, d};
    bus.data_write_n = 2'b00;
    bus.data_read_n  = 2'b11;
    @(posedge clk);
    #1;
    bus.data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.address      = a;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b00;
    sb_push(exp);
    #1;
    sb_pop(name, bus.data_out);
    bus.data_read_n = 2'b11;
  endtask

  task automatic read_cell(input int k, input logic [31:0] exp, input string name);
    wr(6'h00, 8'(k));
    rd(6'h01, exp, $sformatf("%s[%0d]", name, k));
  endtask

  task automatic pix(input int x, input int y, input logic va, input logic [5:0] exp,
                     input string name);
    @(negedge clk);
    pix_x        = 10'(x);
    pix_y        = 10'(y);
    video_active = va;
    sb_push({26'd0, exp});
    @(posedge clk);
    #1;
    sb_pop(name, {26'd0, rgb});
    video_active = 1'b0;
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
    end
  endtask

  // Called just after a negedge: reads CTRL each cycle until busy drops.
  task automatic measure_busy(input string name, input int exp_n);
    int          n;
    bit          done;
    logic [31:0] first_val;
    n    = 0;
    done = 1'b0;
    bus.address      = 6'h03;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b00;
    #1;
    first_val = bus.data_out;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bus.data_out[7]) n++;
      else done = 1'b1;
      if (!done) begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) $display("FAIL %s_timeout: got busy after 200 cycles want idle", name);
    check({name, "_first"}, first_val, 32'h83);
    check({name, "_idle"}, bus.data_out, 32'h03);
    check({name, "_len"}, 32'(n), 32'(exp_n));
    bus.data_read_n = 2'b11;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit done;

    tab[0]  = '{48,  72,  1'b1, 6'h30};
    tab[1]  = '{88,  72,  1'b1, 6'h05};
    tab[2]  = '{48,  72,  1'b0, 6'h00};
    tab[3]  = '{56,  64,  1'b1, 6'h30};
    tab[4]  = '{48,  64,  1'b1, 6'h05};
    tab[5]  = '{47,  72,  1'b1, 6'h00};
    tab[6]  = '{48,  120, 1'b1, 6'h05};
    tab[7]  = '{624, 72,  1'b1, 6'h00};
    tab[8]  = '{623, 72,  1'b1, 6'h05};
    tab[9]  = '{48,  255, 1'b1, 6'h05};
    tab[10] = '{48,  256, 1'b1, 6'h00};
    tab[11] = '{96,  72,  1'b1, 6'h0F};
    tab[12] = '{104, 72,  1'b1, 6'h05};
    tab[13] = '{48,  63,  1'b1, 6'h00};

    reset            = 1'b1;
    bus.address      = 6'h00;
    bus.data_in      = 32'd0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    pix_x            = 10'd0;
    pix_y            = 10'd0;
    video_active     = 1'b0;
    frame_start      = 1'b0;

    // Reset and the automatic clear that follows it.
    @(negedge clk);
    reset = 1'b0;
    check("rgb_reset", {26'd0, rgb}, 32'd0);
    measure_busy("reset_clear", 36);
    rd(6'h00, 32'd0, "ptr_after_reset");
    for (int k = 0; k < 36; k++) read_cell(k, cell_val(6'h0C, 7'h20), "reset_cell");

    // Auto-increment with wrap, out-of-range cursor write.
    wr(6'h00, 8'd35);
    wr(6'h01, 8'h41);
    wr(6'h01, 8'h42);
    rd(6'h00, 32'd1, "ptr_wrap");
    wr(6'h00, 8'd36);
    rd(6'h00, 32'd1, "cursor_oob_ignored");
    read_cell(35, cell_val(6'h0C, 7'h41), "wrap_cell");
    read_cell(0,  cell_val(6'h0C, 7'h42), "wrap_cell");

    // Pixel table: cell 0 'A' fg 0x30, cell 1 'B' fg 0x0F, BG 0x05, cursor off.
    wr(6'h04, 8'h05);
    wr(6'h03, 8'h00);
    wr(6'h00, 8'd0);
    wr(6'h02, 8'h30);
    wr(6'h01, 8'h41);
    wr(6'h02, 8'h0F);
    wr(6'h01, 8'h42);
    for (int i = 0; i < 14; i++)
      pix(tab[i].x, tab[i].y, tab[i].va, tab[i].exp, $sformatf("pix_tab[%0d]", i));

    // Same-cycle DATA write and pixel fetch: the fetch sees the old cell.
    wr(6'h00, 8'd0);
    @(negedge clk);
    bus.address      = 6'h01;
    bus.data_in      = 32'h20;
    bus.data_write_n = 2'b00;
    pix_x            = 10'd48;
    pix_y            = 10'd72;
    video_active     = 1'b1;
    sb_push(32'h30);
    @(posedge clk);
    #1;
    bus.data_write_n = 2'b11;
    video_active     = 1'b0;
    sb_pop("fetch_sees_old", {26'd0, rgb});
    pix(48, 72, 1'b1, 6'h05, "after_overwrite");

    // Cursor inversion and blink.
    wr(6'h00, 8'd0);
    wr(6'h02, 8'h30);
    wr(6'h01, 8'h41);
    wr(6'h00, 8'd0);
    wr(6'h03, 8'h01);
    pix(48, 72, 1'b1, 6'h05, "cursor_inv_lit");
    pix(48, 64, 1'b1, 6'h30, "cursor_inv_bg");
    pix(88, 72, 1'b1, 6'h30, "cursor_inv_gap");
    wr(6'h03, 8'h03);
    pix(48, 72, 1'b1, 6'h05, "blink_phase_start");
    pulse_frames(31);
    pix(48, 72, 1'b1, 6'h05, "blink_31_frames");
    pulse_frames(1);
    pix(48, 72, 1'b1, 6'h30, "blink_off");
    pulse_frames(32);
    pix(48, 72, 1'b1, 6'h05, "blink_on");

    // Clear with a DATA write and a second clear request during it.
    wr(6'h00, 8'd2);
    wr(6'h02, 8'h11);
    wr(6'h03, 8'h83);
    n    = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      bus.data_write_n = 2'b11;
      if (!dbg_state) begin
        done = 1'b1;
      end else begin
        n++;
        if (i == 5) begin
          bus.address = 6'h01; bus.data_in = 32'h5A; bus.data_write_n = 2'b00;
        end
        if (i == 6) begin
          bus.address = 6'h03; bus.data_in = 32'h83; bus.data_write_n = 2'b00;
        end
      end
    end
    bus.data_write_n = 2'b11;
    if (!done) $display("FAIL clear_timeout: got busy after 200 cycles want idle");
    check("clear_len", 32'(n), 32'd36);
    rd(6'h03, 32'h03, "ctrl_after_clear");
    rd(6'h00, 32'd0, "ptr_after_clear");
    for (int k = 0; k < 36; k++) read_cell(k, cell_val(6'h11, 7'h20), "clear_cell");

    // Reset ten cycles into a clear restarts it from cell 0.
    wr(6'h03, 8'h83);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    measure_busy("reset_mid_clear", 36);
    read_cell(0,  cell_val(6'h0C, 7'h20), "restart_cell");
    read_cell(35, cell_val(6'h0C, 7'h20), "restart_cell");

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
